// File: rtl/add_serial_seq.sv
// Operand sequencer for the 8-bit serial adder: collects A/B, fires the adder, captures its sum.
// Optional sum self-check enabled by defining ADD_SERIAL_SEQ_CHECK_EN.
module add_serial_seq #(
    parameter int WIDTH       = 8,
    parameter int WAIT_CYCLES = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [15:0]      op_count,
    output logic             err
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_FIRE,
        S_WAIT,
        S_RESULT
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_en;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic [15:0]      r_op_count;
    logic [CW-1:0]    r_wait_cnt;

    logic w_in_hs;
    logic w_out_hs;
    logic w_capture;

    assign w_in_hs   = in_valid && r_in_ready;
    assign w_out_hs  = r_res_valid && res_ready;
    assign w_capture = (r_state == S_WAIT) && (r_wait_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_A;
            r_in_ready  <= 1'b1;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_en    <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_op_count  <= '0;
            r_wait_cnt  <= '0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_in_hs) begin
                        r_add_a <= in_data;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_in_hs) begin
                        r_add_b    <= in_data;
                        r_in_ready <= 1'b0;
                        r_add_en   <= 1'b1;
                        r_state    <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    r_add_en   <= 1'b0;
                    r_wait_cnt <= WAIT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_res_data  <= add_out;
                        r_res_valid <= 1'b1;
                        r_state     <= S_RESULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CW'(1);
                    end
                end
                S_RESULT: begin
                    if (w_out_hs) begin
                        r_res_valid <= 1'b0;
                        r_op_count  <= r_op_count + 16'd1;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_A;
                    end
                end
                default: begin
                    r_state    <= S_A;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef ADD_SERIAL_SEQ_CHECK_EN
    logic [WIDTH-1:0] w_ref_sum;
    logic             r_err;

    // operands are frozen during the wait, so the reference is exact at capture
    assign w_ref_sum = r_add_a + r_add_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_capture && (w_ref_sum != add_out)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused;

    assign w_unused = w_capture;
    assign err      = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_en    = r_add_en;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_add_serial_seq.sv
// Self-checking bench for add_serial_seq with a latency-accurate adder model.
// Expectations come from operand-pair sums and edge-count latencies.
module tb_add_serial_seq;

    localparam int W  = 8;
    localparam int WC = 9;
`ifdef ADD_SERIAL_SEQ_CHECK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_en;
    logic [W-1:0] add_out = '0;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic [15:0]  op_count;
    logic         err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int e_cyc  = 0;
    int en_cnt = 0;

    bit           force_en  = 1'b0;
    logic [W-1:0] force_val = '0;
    int           acnt      = 0;

    always #5 clk = ~clk;

    add_serial_seq #(.WIDTH(W), .WAIT_CYCLES(WC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_en   (add_en),
        .add_out  (add_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .op_count (op_count),
        .err      (err)
    );

    // serial adder model: garbage while busy, sum valid WIDTH edges after en
    always @(posedge clk) begin
        if (add_en) begin
            add_out <= 8'hEE;
            acnt    <= 1;
        end else if (acnt != 0) begin
            if (acnt == W) begin
                add_out <= force_en ? force_val : W'(add_a + add_b);
                acnt    <= 0;
            end else begin
                acnt <= acnt + 1;
            end
        end
    end

    task automatic step();
        if (add_en) begin
            en_cnt++;
            e_cyc = cyc + 1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, output int edge_n);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        step();
        edge_n   = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [W-1:0] d, output int rise);
        int n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL result_timeout: res_valid=%b after %0d cycles, required 1", res_valid, n);
        end
        d    = res_data;
        rise = cyc;
    endtask

    task automatic accept();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        checks++;
        if ({in_ready, add_a, add_b, add_en, res_valid, res_data, op_count, err}
            !== {1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL %s: rdy=%b a=%h b=%h en=%b rv=%b rd=%h cnt=%0d err=%b, required rdy=1 rest 0",
                     tag, in_ready, add_a, add_b, add_en, res_valid, res_data, op_count, err);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        res_ready = 1'b0;
        step();
        step();
        chk_reset_vals("reset_state");
        rst = 1'b0;
        step();
        chk_reset_vals("after_release");
    endtask

    task automatic test_basic();
        int ta, tb2, rise, en0;
        logic [W-1:0] d;
        en0 = en_cnt;
        send_beat(8'h35, ta);
        send_beat(8'h4A, tb2);
        checks++;
        if (tb2 !== ta + 1) begin
            errors++;
            $display("FAIL b_edge: got %0d, required %0d", tb2, ta + 1);
        end
        wait_result(d, rise);
        checks++;
        if (en_cnt - en0 !== 1) begin
            errors++;
            $display("FAIL en_pulses: got %0d, required 1", en_cnt - en0);
        end
        checks++;
        if (rise - e_cyc !== WC) begin
            errors++;
            $display("FAIL en_to_result: got %0d, required %0d", rise - e_cyc, WC);
        end
        checks++;
        if (rise - ta !== WC + 2) begin
            errors++;
            $display("FAIL best_latency: got %0d, required %0d", rise - ta, WC + 2);
        end
        checks++;
        if (d !== 8'h7F) begin
            errors++;
            $display("FAIL sum_35_4a: got %h, required 7f", d);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rdy_in_result: got %b, required 0", in_ready);
        end
        accept();
        checks++;
        if (op_count !== 16'd1 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_handoff: cnt=%0d rdy=%b rv=%b, required 1 1 0", op_count, in_ready, res_valid);
        end
    endtask

    task automatic test_carry();
        int t, rise;
        logic [W-1:0] d;
        send_beat(8'hFF, t);
        send_beat(8'h01, t);
        wait_result(d, rise);
        checks++;
        if (d !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL carry_drop: sum=%h err=%b, required 00 0", d, err);
        end
        accept();
    endtask

    task automatic run_stream(input logic [W-1:0] beats[$], input bit rnd, input int max_cyc);
        logic [W-1:0] exp_q[$];
        logic [W-1:0] a_hold = '0;
        logic [W-1:0] cur_a  = '0;
        logic [W-1:0] cur_b  = '0;
        logic [W-1:0] e;
        bit   second = 1'b0;
        bit   busy   = 1'b0;
        bit   out_hs;
        int   bad    = 0;
        int   got    = 0;
        int   n      = 0;
        int   npairs = beats.size() / 2;
        logic [15:0] oc0 = op_count;
        while (got < npairs && n < max_cyc) begin
            in_valid  = (beats.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            in_data   = (beats.size() > 0) ? beats[0] : '0;
            res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy && (in_ready !== 1'b0 || add_a !== cur_a || add_b !== cur_b))
                bad++;
            out_hs = res_valid && res_ready;
            if (in_valid && in_ready) begin
                if (!second) begin
                    a_hold = beats[0];
                end else begin
                    cur_a = a_hold;
                    cur_b = beats[0];
                    exp_q.push_back(a_hold + beats[0]);
                    busy = 1'b1;
                end
                second = !second;
                void'(beats.pop_front());
            end
            if (out_hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checks++;
                if (res_data !== e) begin
                    errors++;
                    $display("FAIL stream_sum%0d: got %h, required %h", got, res_data, e);
                end
                got++;
                busy = 1'b0;
            end
            step();
            n++;
            if (out_hs) begin
                checks++;
                if (op_count !== 16'(oc0 + got)) begin
                    errors++;
                    $display("FAIL stream_count: got %0d, required %0d", op_count, oc0 + got);
                end
            end
        end
        in_valid  = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (got !== npairs) begin
            errors++;
            $display("FAIL stream_timeout: got %0d results, required %0d", got, npairs);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_hold: %0d cycles with rdy high or operands moved, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        q = '{8'h10, 8'h20, 8'h03, 8'h04};
        run_stream(q, 1'b0, 200);
    endtask

    task automatic test_hold();
        int t, rise;
        logic [W-1:0] a, b, d, e;
        logic [15:0] oc;
        a = W'($urandom);
        b = W'($urandom);
        e = a + b;
        send_beat(a, t);
        send_beat(b, t);
        wait_result(d, rise);
        oc = op_count;
        res_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (res_data !== e || res_valid !== 1'b1 || in_ready !== 1'b0 || op_count !== oc) begin
                errors++;
                $display("FAIL hold_c%0d: rd=%h rv=%b rdy=%b cnt=%0d, required %h 1 0 %0d",
                         i, res_data, res_valid, in_ready, op_count, e, oc);
            end
        end
        accept();
        checks++;
        if (op_count !== 16'(oc + 1)) begin
            errors++;
            $display("FAIL hold_release: cnt=%0d, required %0d", op_count, oc + 1);
        end
    endtask

    task automatic test_rst_mid();
        int t, rise;
        logic [W-1:0] d;
        send_beat(8'h77, t);
        send_beat(8'h11, t);
        step();
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        rst = 1'b0;
        step();
        send_beat(8'h01, t);
        send_beat(8'h02, t);
        wait_result(d, rise);
        checks++;
        if (d !== 8'h03) begin
            errors++;
            $display("FAIL post_reset_sum: got %h, required 03", d);
        end
        accept();
        checks++;
        if (op_count !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d, required 1", op_count);
        end
    endtask

    task automatic test_err();
        int t, rise;
        logic [W-1:0] d;
        force_en  = 1'b1;
        force_val = 8'hAA;
        send_beat(8'h01, t);
        send_beat(8'h01, t);
        wait_result(d, rise);
        checks++;
        if (d !== 8'hAA || err !== ERR_EXP) begin
            errors++;
            $display("FAIL bad_adder: rd=%h err=%b, required aa %b", d, err, ERR_EXP);
        end
        accept();
        force_en = 1'b0;
        send_beat(8'h05, t);
        send_beat(8'h06, t);
        wait_result(d, rise);
        checks++;
        if (d !== 8'h0B || err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_sticky: rd=%h err=%b, required 0b %b", d, err, ERR_EXP);
        end
        accept();
    endtask

    task automatic test_random();
        logic [W-1:0] q[$];
        for (int i = 0; i < 40; i++)
            q.push_back(W'($urandom));
        run_stream(q, 1'b1, 3000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_hold();
        test_rst_mid();
        test_random();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
